// File: rtl/alu_op_encoder.sv
// alu_op_encoder
//   RV32I instruction word -> 4-bit ALU Operation code, sign-extended
//   immediate and operand/branch qualifiers. One cycle of latency through a
//   main output register backed by a single skid register, so in_ready is a
//   pure register output and never depends combinationally on out_ready.
//
//   Optional feature macro: ALU_OP_ENCODER_ILLEGAL_EN
//     defined   -> `illegal` is registered alongside each unencodable entry
//                  and a sticky saturating (255) count of accepted
//                  unencodable instructions is kept; it clears on reset.
//     undefined -> `illegal` is tied to 0 and the counter does not exist.
//   Unencodable instructions produce Operation 1111 in both builds.
module alu_op_encoder #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     alu_src_imm,
    output logic                     br_invert,
    output logic [DATA_WIDTH-1:0]    imm,
    output logic                     illegal
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111
    } opcode_e;

    // ALU operation codes as decoded by the execute stage. ALU_NONE makes
    // the ALU return 0 and doubles as the "unencodable" marker.
    typedef enum logic [OPCODE_LENGTH-1:0] {
        ALU_AND  = 4'b0000,
        ALU_XOR  = 4'b0001,
        ALU_SUB  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_ADD  = 4'b0100,
        ALU_SRA  = 4'b0101,
        ALU_EQ   = 4'b1000,
        ALU_SLL  = 4'b1001,
        ALU_LUI  = 4'b1010,
        ALU_SRL  = 4'b1100,
        ALU_SLT  = 4'b1110,
        ALU_NONE = 4'b1111
    } alu_op_e;

    // One buffered command: everything the execute stage consumes.
    typedef struct packed {
        alu_op_e               op;
        logic                  src_imm;
        logic                  br_inv;
        logic [DATA_WIDTH-1:0] imm;
`ifdef ALU_OP_ENCODER_ILLEGAL_EN
        logic                  ill;
`endif
    } cmd_t;

    // ------------------------------------------------------------------
    // Instruction fields and immediate formats
    // ------------------------------------------------------------------
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  f7_zero;
    logic                  f7_alt;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] imm_b;
    logic [DATA_WIDTH-1:0] imm_u;
    logic [DATA_WIDTH-1:0] imm_sh;

    assign opcode  = in_instr[6:0];
    assign funct3  = in_instr[14:12];
    assign funct7  = in_instr[31:25];
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    assign imm_i  = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_sh = {{(DATA_WIDTH-5){1'b0}}, in_instr[24:20]};

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    cmd_t    dec_cmd;
    alu_op_e dec_op;
    logic    dec_src;
    logic    dec_inv;
    logic [DATA_WIDTH-1:0] dec_imm;

    // Combinational decode of the offered instruction into a command.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path through it leaves a value unassigned and infers a latch.
        dec_op  = ALU_NONE;
        dec_src = 1'b0;
        dec_inv = 1'b0;
        dec_imm = '0;
        dec_cmd = '0;

        case (opcode)
            OPC_OP: begin
                case (funct3)
                    3'b000: begin
                        if (f7_zero)     dec_op = ALU_ADD;
                        else if (f7_alt) dec_op = ALU_SUB;
                    end
                    3'b001: if (f7_zero) dec_op = ALU_SLL;
                    3'b010: if (f7_zero) dec_op = ALU_SLT;
                    3'b100: if (f7_zero) dec_op = ALU_XOR;
                    3'b101: begin
                        if (f7_zero)     dec_op = ALU_SRL;
                        else if (f7_alt) dec_op = ALU_SRA;
                    end
                    3'b110: if (f7_zero) dec_op = ALU_OR;
                    3'b111: if (f7_zero) dec_op = ALU_AND;
                    default: ;
                endcase
            end

            OPC_OP_IMM: begin
                dec_src = 1'b1;
                dec_imm = imm_i;
                case (funct3)
                    3'b000: dec_op = ALU_ADD;
                    3'b010: dec_op = ALU_SLT;
                    3'b100: dec_op = ALU_XOR;
                    3'b110: dec_op = ALU_OR;
                    3'b111: dec_op = ALU_AND;
                    3'b001: begin
                        dec_imm = imm_sh;
                        if (f7_zero) dec_op = ALU_SLL;
                    end
                    3'b101: begin
                        dec_imm = imm_sh;
                        if (f7_zero)     dec_op = ALU_SRL;
                        else if (f7_alt) dec_op = ALU_SRA;
                    end
                    default: ;
                endcase
            end

            OPC_LUI: begin
                dec_op  = ALU_LUI;
                dec_src = 1'b1;
                dec_imm = imm_u;
            end

            OPC_LOAD, OPC_JALR: begin
                dec_op  = ALU_ADD;
                dec_src = 1'b1;
                dec_imm = imm_i;
            end

            OPC_STORE: begin
                dec_op  = ALU_ADD;
                dec_src = 1'b1;
                dec_imm = imm_s;
            end

            OPC_BRANCH: begin
                dec_imm = imm_b;
                case (funct3)
                    3'b000: dec_op = ALU_EQ;
                    3'b001: begin
                        dec_op  = ALU_EQ;
                        dec_inv = 1'b1;
                    end
                    3'b100: dec_op = ALU_SLT;
                    3'b101: begin
                        dec_op  = ALU_SLT;
                        dec_inv = 1'b1;
                    end
                    default: ;
                endcase
            end

            default: ;
        endcase

        // Unencodable entries carry no immediate and no qualifiers, whatever
        // partial decode happened above.
        if (dec_op == ALU_NONE) begin
            dec_src = 1'b0;
            dec_inv = 1'b0;
            dec_imm = '0;
        end

        dec_cmd.op      = dec_op;
        dec_cmd.src_imm = dec_src;
        dec_cmd.br_inv  = dec_inv;
        dec_cmd.imm     = dec_imm;
`ifdef ALU_OP_ENCODER_ILLEGAL_EN
        dec_cmd.ill     = (dec_op == ALU_NONE);
`endif
    end

    // ------------------------------------------------------------------
    // Output register + skid register
    // ------------------------------------------------------------------
    cmd_t out_cmd;
    cmd_t skid_cmd;
    logic skid_valid;
    logic push;
    logic pop;
    logic out_free;

    // Ready only depends on skid occupancy, which is a flop.
    assign in_ready = ~skid_valid;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    // The output register can take a new entry this edge.
    assign out_free = ~out_valid | pop;

    // Occupancy flags; reset and flush discard everything held.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values, independent of block ordering.
        if (reset || flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            // The skid entry (if any) is older than anything offered now;
            // in_ready is low while it is held, so push cannot coincide.
            out_valid  <= skid_valid | push;
            skid_valid <= 1'b0;
        end else if (push) begin
            skid_valid <= 1'b1;
        end
    end

    // Output payload: reloaded only when it moves, so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_cmd <= '0;
        end else if (!flush && out_free && (skid_valid || push)) begin
            out_cmd <= skid_valid ? skid_cmd : dec_cmd;
        end
    end

    // Skid payload captures an accepted entry while the output register is stalled.
    always_ff @(posedge clk) begin
        // NOTE: the skid payload has no reset; it is only ever observed
        // through skid_valid, which is reset.
        if (push && !out_free) begin
            skid_cmd <= dec_cmd;
        end
    end

    assign Operation   = out_cmd.op;
    assign alu_src_imm = out_cmd.src_imm;
    assign br_invert   = out_cmd.br_inv;
    assign imm         = out_cmd.imm;

`ifdef ALU_OP_ENCODER_ILLEGAL_EN
    logic [7:0] ill_count;

    assign illegal = out_cmd.ill;

    // Sticky saturating count of accepted unencodable instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            ill_count <= 8'd0;
        end else if (push && !flush && dec_cmd.ill && (ill_count != 8'hFF)) begin
            ill_count <= ill_count + 8'd1;
        end
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_encoder.sv
// tb_alu_op_encoder
//   Directed vectors with hand-computed expectations, fed through a FIFO
//   occupancy model (queue of expected commands, at most two held). One
//   compare process checks out_valid/in_ready/fields against the model on
//   every negedge; a few literal checks pin specific cycles.
module tb_alu_op_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  Operation;
    logic        alu_src_imm;
    logic        br_invert;
    logic [31:0] imm;
    logic        illegal;

    always #5 clk = ~clk;

    alu_op_encoder #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Operation   (Operation),
        .alu_src_imm (alu_src_imm),
        .br_invert   (br_invert),
        .imm         (imm),
        .illegal     (illegal)
    );

`ifdef ALU_OP_ENCODER_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  op;
        logic        src;
        logic        inv;
        logic [31:0] imm;
        logic        chk_imm;
        logic        unenc;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en   = 1'b0;
    vec_t tbl[$];
    vec_t model_q[$];
    vec_t cur_vec;

    // out_ready source: manual level or a fixed stall pattern
    logic        ready_man = 1'b1;
    bit          pat_en    = 1'b0;
    logic [15:0] pat       = 16'b1011_0010_1110_0101;
    int          pat_idx   = 0;
    assign out_ready = pat_en ? pat[pat_idx[3:0]] : ready_man;

    always @(posedge clk) begin
        #1 pat_idx = pat_idx + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [3:0] op,
                                input logic src, input logic inv, input logic [31:0] im,
                                input logic chk_imm, input logic unenc);
        vec_t v;
        v.instr = instr; v.op = op; v.src = src; v.inv = inv;
        v.imm = im; v.chk_imm = chk_imm; v.unenc = unenc;
        return v;
    endfunction

    // Compare DUT against the model, then advance the model for the coming edge.
    always @(negedge clk) begin
        bit do_pop;
        bit do_push;
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
            check("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
            if (out_valid && model_q.size() > 0) begin
                check($sformatf("op[%h]", model_q[0].instr), 32'(Operation), 32'(model_q[0].op));
                check($sformatf("src[%h]", model_q[0].instr), 32'(alu_src_imm), 32'(model_q[0].src));
                check($sformatf("inv[%h]", model_q[0].instr), 32'(br_invert), 32'(model_q[0].inv));
                check($sformatf("ill[%h]", model_q[0].instr), 32'(illegal),
                      32'(model_q[0].unenc & ILL_EN));
                if (model_q[0].chk_imm)
                    check($sformatf("imm[%h]", model_q[0].instr), imm, model_q[0].imm);
            end
        end
        if (reset || flush) begin
            model_q.delete();
        end else begin
            do_pop  = (model_q.size() > 0) && out_ready;
            do_push = in_valid && (model_q.size() < 2);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(cur_vec);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_instr = v.instr;
        cur_vec  = v;
    endtask

    // Offer one instruction until accepted (bounded).
    task automatic push_vec(input vec_t v);
        bit done = 1'b0;
        drive(v);
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check($sformatf("accept[%h]", v.instr), 32'(done), 32'd1);
    endtask

    // Wait (bounded) until the DUT and model are both empty, then re-align.
    task automatic wait_empty();
        bit empty = 1'b0;
        for (int k = 0; k < 60 && !empty; k++) begin
            @(negedge clk);
            if (!out_valid && model_q.size() == 0) empty = 1'b1;
        end
        check("drain", 32'(empty), 32'd1);
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // idx: 0 add 1 sub 2 addi 3 lui 4 srai 5 bne 6 bltu 7 lw 8 bge 9 sw
        tbl.push_back(mk(32'h003100B3, 4'b0100, 0, 0, 32'h0,        0, 0)); // add
        tbl.push_back(mk(32'h403100B3, 4'b0010, 0, 0, 32'h0,        0, 0)); // sub
        tbl.push_back(mk(32'hFFF00093, 4'b0100, 1, 0, 32'hFFFFFFFF, 1, 0)); // addi -1
        tbl.push_back(mk(32'h123450B7, 4'b1010, 1, 0, 32'h12345000, 1, 0)); // lui
        tbl.push_back(mk(32'h4030D093, 4'b0101, 1, 0, 32'h00000003, 1, 0)); // srai 3
        tbl.push_back(mk(32'h00209463, 4'b1000, 0, 1, 32'h00000008, 1, 0)); // bne +8
        tbl.push_back(mk(32'h0020E463, 4'b1111, 0, 0, 32'h0,        1, 1)); // bltu
        tbl.push_back(mk(32'h00412083, 4'b0100, 1, 0, 32'h00000004, 1, 0)); // lw 4
        tbl.push_back(mk(32'h0020D463, 4'b1110, 0, 1, 32'h00000008, 1, 0)); // bge +8
        tbl.push_back(mk(32'hFE312E23, 4'b0100, 1, 0, 32'hFFFFFFFC, 1, 0)); // sw -4
        tbl.push_back(mk(32'h003140B3, 4'b0001, 0, 0, 32'h0,        0, 0)); // xor
        tbl.push_back(mk(32'h003160B3, 4'b0011, 0, 0, 32'h0,        0, 0)); // or
        tbl.push_back(mk(32'h003170B3, 4'b0000, 0, 0, 32'h0,        0, 0)); // and
        tbl.push_back(mk(32'h003120B3, 4'b1110, 0, 0, 32'h0,        0, 0)); // slt
        tbl.push_back(mk(32'h003110B3, 4'b1001, 0, 0, 32'h0,        0, 0)); // sll
        tbl.push_back(mk(32'h003150B3, 4'b1100, 0, 0, 32'h0,        0, 0)); // srl
        tbl.push_back(mk(32'h403150B3, 4'b0101, 0, 0, 32'h0,        0, 0)); // sra
        tbl.push_back(mk(32'h003130B3, 4'b1111, 0, 0, 32'h0,        1, 1)); // sltu
        tbl.push_back(mk(32'h023100B3, 4'b1111, 0, 0, 32'h0,        1, 1)); // funct7 0000001
        tbl.push_back(mk(32'h403140B3, 4'b1111, 0, 0, 32'h0,        1, 1)); // xor, funct7 0100000
        tbl.push_back(mk(32'h0030D093, 4'b1100, 1, 0, 32'h00000003, 1, 0)); // srli 3
        tbl.push_back(mk(32'h01F09093, 4'b1001, 1, 0, 32'h0000001F, 1, 0)); // slli 31
        tbl.push_back(mk(32'h41F09093, 4'b1111, 0, 0, 32'h0,        1, 1)); // slli bad funct7
        tbl.push_back(mk(32'hFFF12093, 4'b1110, 1, 0, 32'hFFFFFFFF, 1, 0)); // slti -1
        tbl.push_back(mk(32'hFFF13093, 4'b1111, 0, 0, 32'h0,        1, 1)); // sltiu
        tbl.push_back(mk(32'h7FF14093, 4'b0001, 1, 0, 32'h000007FF, 1, 0)); // xori 0x7ff
        tbl.push_back(mk(32'h010280E7, 4'b0100, 1, 0, 32'h00000010, 1, 0)); // jalr 16
        tbl.push_back(mk(32'hFE208CE3, 4'b1000, 0, 0, 32'hFFFFFFF8, 1, 0)); // beq -8
        tbl.push_back(mk(32'h0020C463, 4'b1110, 0, 0, 32'h00000008, 1, 0)); // blt +8
        tbl.push_back(mk(32'h0020F463, 4'b1111, 0, 0, 32'h0,        1, 1)); // bgeu
        tbl.push_back(mk(32'h12345097, 4'b1111, 0, 0, 32'h0,        1, 1)); // auipc
        tbl.push_back(mk(32'h0000000F, 4'b1111, 0, 0, 32'h0,        1, 1)); // fence

        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_instr = 32'h0;
        cur_vec  = tbl[0];
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_op", 32'(Operation), 32'h0);
        check("rst_imm", imm, 32'h0);
        check("rst_src", 32'(alu_src_imm), 32'd0);
        check("rst_inv", 32'(br_invert), 32'd0);
        check("rst_ill", 32'(illegal), 32'd0);
        tick();

        // add then sub on consecutive cycles
        drive(tbl[0]);
        in_valid = 1'b1;
        tick();
        drive(tbl[1]);
        @(negedge clk);
        check("add_op", 32'(Operation), 32'h4);
        check("add_src", 32'(alu_src_imm), 32'd0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("sub_op", 32'(Operation), 32'h2);
        check("sub_valid", 32'(out_valid), 32'd1);
        wait_empty();

        // bltu: unencodable
        push_vec(tbl[6]);
        @(negedge clk);
        check("bltu_op", 32'(Operation), 32'hF);
        check("bltu_ill", 32'(illegal), 32'(ILL_EN));
        wait_empty();

        // Whole table, back-to-back, under a stall pattern on out_ready
        pat_en = 1'b1;
        foreach (tbl[i]) push_vec(tbl[i]);
        pat_en = 1'b0;
        ready_man = 1'b1;
        wait_empty();

        // Stall: two accepted, third refused, then drained in order
        ready_man = 1'b0;
        push_vec(tbl[0]);
        push_vec(tbl[7]);
        drive(tbl[8]);
        in_valid = 1'b1;
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_op", 32'(Operation), 32'h4);
        tick();
        @(negedge clk);
        check("full_hold_op", 32'(Operation), 32'h4);
        tick();
        ready_man = 1'b1;
        push_vec(tbl[8]);
        wait_empty();

        // Flush with buffer full and an offered instruction
        ready_man = 1'b0;
        push_vec(tbl[2]);
        push_vec(tbl[3]);
        drive(tbl[9]);
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_full_valid", 32'(out_valid), 32'd0);
        check("flush_full_ready", 32'(in_ready), 32'd1);
        tick();
        ready_man = 1'b1;
        repeat (4) tick();

        // Flush with one entry held: the same-cycle input must be dropped
        ready_man = 1'b0;
        push_vec(tbl[4]);
        drive(tbl[9]);
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_one_valid", 32'(out_valid), 32'd0);
        tick();
        ready_man = 1'b1;
        repeat (4) tick();

        // Reset mid-stream with buffer full
        ready_man = 1'b0;
        push_vec(tbl[5]);
        push_vec(tbl[3]);
        drive(tbl[9]);
        in_valid = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst2_valid", 32'(out_valid), 32'd0);
        check("rst2_ready", 32'(in_ready), 32'd1);
        check("rst2_op", 32'(Operation), 32'h0);
        check("rst2_imm", imm, 32'h0);
        tick();

        // Reset mid-stream with one entry held and an input offered
        push_vec(tbl[4]);
        drive(tbl[9]);
        in_valid = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        ready_man = 1'b1;
        @(negedge clk);
        check("rst3_valid", 32'(out_valid), 32'd0);
        tick();
        repeat (4) tick();

        // After all that, normal operation still works
        push_vec(tbl[5]);
        wait_empty();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
